counter64_api: RTL

Register-bus front end for a bank of `counter64` instances. It decodes API reads and writes and drives the per-counter `i_rst` and `i_lsb_sample` strobes. It returns coherent 64-bit values as an MSB-then-LSB read pair, and flags reads made out of sequence. It sits between the NTS engine API bus and the statistics counter bank.

---
 rtl/counter64_api.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/counter64_api.sv
`default_nettype none
// ============================================================================
// Module      : counter64_api
// Description : Register-bus front end for a bank of counter64 instances.
//               Decodes API reads and writes.
//               Returns 64-bit counter values as a coherent MSB-then-LSB pair.
//               Drives the per-counter clear and LSB-sample strobes.
//               Flags out-of-sequence and dropped requests in sticky bits.
//               Optional macro COUNTER64_API_READ_CLEAR_EN: an LSB read also
//               clears the counter that was read.
// Revision    : 1.0 - initial release
// ============================================================================
module counter64_api #(
    parameter int NUM_COUNTERS = 8,
    parameter int ADDR_W       = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cs,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_address,
    input  logic [31:0]               i_write_data,
    output logic [31:0]               o_read_data,
    output logic                      o_read_valid,
    output logic                      o_busy,
    input  logic [32*NUM_COUNTERS-1:0] i_msb,
    input  logic [32*NUM_COUNTERS-1:0] i_lsb,
    output logic [NUM_COUNTERS-1:0]   o_rst,
    output logic [NUM_COUNTERS-1:0]   o_lsb_sample
);

    localparam logic [7:0] c_CTRL_ADDR   = 8'h80;
    localparam logic [7:0] c_STATUS_ADDR = 8'h81;
    localparam logic [7:0] c_NUM_CNT     = 8'(NUM_COUNTERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR1 = 2'd1,
        ST_CLR2 = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic [NUM_COUNTERS-1:0] r_rst;
    logic [31:0]             r_read_data;
    logic                    r_read_valid;
    logic                    r_armed;
    logic [5:0]              r_armed_idx;
    logic                    r_seq_err;
    logic                    r_drop_err;

    logic                    w_accept;
    logic                    w_rd;
    logic                    w_wr;
    logic                    w_drop_evt;
    logic [7:0]              w_lo;
    logic                    w_hi_zero;
    logic                    w_cnt_region;
    logic [5:0]              w_idx;
    logic                    w_idx_ok;
    logic                    w_is_lsb;
    logic                    w_msb_rd;
    logic                    w_lsb_rd;
    logic                    w_status_wr;
    logic                    w_ctrl_wr;
    logic                    w_seq_evt;
    logic                    w_armed_match;
    logic                    w_armed_hit;
    logic [31:0]             w_msb_word;
    logic [31:0]             w_lsb_word;
    logic [31:0]             w_rdata;
    logic [NUM_COUNTERS-1:0] w_idx_onehot;
    logic [NUM_COUNTERS-1:0] w_ctrl_mask;
    logic [NUM_COUNTERS-1:0] w_rc_mask;
    logic [NUM_COUNTERS-1:0] w_clr_mask;
    logic                    w_unused_ok;

    // Request qualification; nothing is accepted while reset is asserted so
    // the combinational sample strobe stays quiet during reset.
    assign w_accept   = i_cs & ~r_busy & ~i_reset;
    assign w_rd       = w_accept & ~i_we;
    assign w_wr       = w_accept & i_we;
    assign w_drop_evt = i_cs & r_busy;

    // Address decode: 0x00..0x7F is the counter window, 2k = MSB, 2k+1 = LSB.
    assign w_lo         = i_address[7:0];
    assign w_hi_zero    = ((i_address >> 8) == '0);
    assign w_cnt_region = w_hi_zero & ~w_lo[7];
    assign w_idx        = w_lo[6:1];
    assign w_is_lsb     = w_lo[0];
    assign w_idx_ok     = w_cnt_region && (int'(w_idx) < NUM_COUNTERS);
    assign w_msb_rd     = w_rd & w_idx_ok & ~w_is_lsb;
    assign w_lsb_rd     = w_rd & w_idx_ok & w_is_lsb;
    assign w_status_wr  = w_wr & w_hi_zero & (w_lo == c_STATUS_ADDR);
    assign w_ctrl_wr    = w_wr & w_hi_zero & (w_lo == c_CTRL_ADDR);

    assign w_armed_match = r_armed && (r_armed_idx == w_idx);
    assign w_seq_evt     = w_lsb_rd & ~w_armed_match;

    // Every bit of the write data is architecturally visible only through
    // the slices used below; this reduction keeps the rest accounted for.
    assign w_unused_ok = &{1'b0, i_write_data};

    // Counter word select, one-hot of the addressed counter and armed-hit test.
    always_comb begin
        w_msb_word   = '0;
        w_lsb_word   = '0;
        w_idx_onehot = '0;
        w_armed_hit  = 1'b0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (int'(w_idx) == k) begin
                w_msb_word      = i_msb[32*k +: 32];
                w_lsb_word      = i_lsb[32*k +: 32];
                w_idx_onehot[k] = 1'b1;
            end
            if ((int'(r_armed_idx) == k) && w_clr_mask[k]) begin
                w_armed_hit = 1'b1;
            end
        end
    end

    // MSB reads ask the addressed counter to capture its LSB this cycle.
    assign o_lsb_sample = w_msb_rd ? w_idx_onehot : '0;

    // Clear mask from CTRL writes, plus the optional read-to-clear source.
    assign w_ctrl_mask = i_write_data[31] ? {NUM_COUNTERS{1'b1}}
                                          : i_write_data[NUM_COUNTERS-1:0];
`ifdef COUNTER64_API_READ_CLEAR_EN
    assign w_rc_mask = w_lsb_rd ? w_idx_onehot : '0;
`else
    assign w_rc_mask = '0;
`endif
    assign w_clr_mask = (w_ctrl_wr ? w_ctrl_mask : '0) | w_rc_mask;

    // Read data mux for the register map; unmapped addresses read zero.
    always_comb begin
        w_rdata = '0;
        if (w_idx_ok) begin
            w_rdata = w_is_lsb ? w_lsb_word : w_msb_word;
        end else if (w_hi_zero && (w_lo == c_STATUS_ADDR)) begin
            w_rdata = {16'h0000, c_NUM_CNT, 6'b000000, r_drop_err, r_seq_err};
        end
    end

    // Read response, arming, sticky errors and the clear/busy sequencer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_rst        <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_armed      <= 1'b0;
            r_armed_idx  <= '0;
            r_seq_err    <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_read_valid <= w_rd;
            if (w_rd) begin
                r_read_data <= w_rdata;
            end

            if (w_msb_rd) begin
                r_armed     <= 1'b1;
                r_armed_idx <= w_idx;
            end else if ((w_lsb_rd && w_armed_match) || w_armed_hit) begin
                r_armed <= 1'b0;
            end

            // A new error event wins over a same-cycle write-one-to-clear.
            r_seq_err  <= w_seq_evt |
                          (r_seq_err & ~(w_status_wr & i_write_data[0]));
            r_drop_err <= w_drop_evt |
                          (r_drop_err & ~(w_status_wr & i_write_data[1]));

            case (r_state)
                ST_IDLE: begin
                    if (|w_clr_mask) begin
                        r_state <= ST_CLR1;
                        r_busy  <= 1'b1;
                        r_rst   <= w_clr_mask;
                    end else begin
                        r_rst   <= '0;
                    end
                end
                ST_CLR1: begin
                    r_state <= ST_CLR2;
                    r_rst   <= '0;
                end
                ST_CLR2: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_rst   <= '0;
                end
            endcase
        end
    end

    assign o_read_data  = r_read_data;
    assign o_read_valid = r_read_valid;
    assign o_busy       = r_busy;
    assign o_rst        = r_rst;

endmodule
`default_nettype wire
